mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 210 +++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 multiply/divide unit with HI/LO registers.
// MULT/MULTU take 32 shift-add cycles, DIV/DIVU take 32 restoring-divide cycles,
// MTHI/MTLO write HI/LO directly on the accept edge.
// Optional feature macro: MDU_DIV_EN compiles in the divide datapath; without it
// DIV/DIVU are accepted and complete on the next edge with HI/LO unchanged.
// Handshake: a request is accepted on a rising edge where start=1 and busy=0;
// op/A/B are captured on that edge, and start while busy=1 is ignored. done is
// a one-cycle pulse in the cycle after HI/LO were loaded with a MULT/DIV result.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    // Multiply: {partial product high, multiplier}. Divide: {remainder, dividend/quotient}.
    logic [63:0] acc_q, acc_d;
    // Multiplicand magnitude for MUL, divisor magnitude for DIV.
    logic [31:0] mcand_q, mcand_d;
    // Product sign for MUL, quotient sign for DIV.
    logic        neg_q, neg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Operand sign handling: ops 0 and 2 are the signed variants (op[0]=0).
    logic        signed_op;
    logic        a_neg, b_neg;
    logic [31:0] mag_a, mag_b;

    // One shift-add multiply step and the sign-corrected final product.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [63:0] mul_res;

`ifdef MDU_DIV_EN
    logic        rem_neg_q, rem_neg_d;
    logic        div_zero_q, div_zero_d;
    logic [31:0] dividend_q, dividend_d;

    // One restoring-divide step; the shifted remainder needs 33 bits.
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic [63:0] div_next;
    logic [31:0] quo_res, rem_res;
`endif

    assign busy = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign done = (state_q == ST_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Operand magnitudes and the per-cycle datapath steps.
    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & A[31];
        b_neg     = signed_op & B[31];
        mag_a     = a_neg ? (~A + 32'd1) : A;
        mag_b     = b_neg ? (~B + 32'd1) : B;

        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
        mul_next  = {mul_sum, acc_q[31:1]};
        mul_res   = neg_q ? (~mul_next + 64'd1) : mul_next;

`ifdef MDU_DIV_EN
        div_shift = {acc_q[63:32], acc_q[31]};
        div_diff  = {1'b0, div_shift} - {2'b00, mcand_q};
        if (div_diff[33]) begin
            div_next = {div_shift[31:0], acc_q[30:0], 1'b0};
        end else begin
            div_next = {div_diff[31:0], acc_q[30:0], 1'b1};
        end
        quo_res = neg_q ? (~div_next[31:0] + 32'd1) : div_next[31:0];
        rem_res = rem_neg_q ? (~div_next[63:32] + 32'd1) : div_next[63:32];
`endif
    end

    // Next-state and register-update logic for the FSM, counter and HI/LO.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MDU_DIV_EN
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        dividend_d = dividend_q;
`endif

        case (state_q)
            ST_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_DONE;
                    hi_d    = mul_res[63:32];
                    lo_d    = mul_res[31:0];
                end
            end
`ifdef MDU_DIV_EN
            ST_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_DONE;
                    if (div_zero_q) begin
                        hi_d = dividend_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = rem_res;
                        lo_d = quo_res;
                    end
                end
            end
`endif
            default: begin
                // IDLE and DONE both accept a new request; DONE lasts one cycle.
                state_d = ST_IDLE;
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_d = ST_MUL;
                            cnt_d   = 5'd0;
                            acc_d   = {32'd0, mag_b};
                            mcand_d = mag_a;
                            neg_d   = a_neg ^ b_neg;
                        end
                        OP_DIV, OP_DIVU: begin
`ifdef MDU_DIV_EN
                            state_d    = ST_DIV;
                            cnt_d      = 5'd0;
                            acc_d      = {32'd0, mag_a};
                            mcand_d    = mag_b;
                            neg_d      = a_neg ^ b_neg;
                            rem_neg_d  = a_neg;
                            div_zero_d = (B == 32'd0);
                            dividend_d = A;
`else
                            // Divider not built: complete immediately, HI/LO untouched.
                            state_d = ST_DONE;
`endif
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            mcand_q <= 32'd0;
            neg_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

`ifdef MDU_DIV_EN
    // Divide-only side registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            dividend_q <= 32'd0;
        end else begin
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            dividend_q <= dividend_d;
        end
    end
`endif

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and randomized checks of mul_div_unit against a
// plain-arithmetic reference model of HI/LO, timing and handshake behaviour.
module tb_mul_div_unit;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    // Reference HI/LO.
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    mul_div_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (a_in),
        .B     (b_in),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one accepted operation, from plain arithmetic.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin
                p = 64'(sa * sb);
                hi_m = p[63:32];
                lo_m = p[31:0];
            end
            3'd1: begin
                p = {32'd0, a} * {32'd0, b};
                hi_m = p[63:32];
                lo_m = p[31:0];
            end
            3'd2, 3'd3: begin
                if (DIV_EN) begin
                    if (b == 32'd0) begin
                        hi_m = a;
                        lo_m = 32'hFFFF_FFFF;
                    end else if (o == 3'd2) begin
                        q = sa / sb;
                        r = sa % sb;
                        lo_m = q[31:0];
                        hi_m = r[31:0];
                    end else begin
                        lo_m = a / b;
                        hi_m = a % b;
                    end
                end
            end
            3'd4: hi_m = a;
            3'd5: lo_m = a;
            default: ;
        endcase
    endfunction

    // Issue one MULT/DIV request and follow it to its done pulse. Optionally
    // inject an ignored MTLO start at busy cycle inj_at, and optionally chain
    // an MTHI request accepted in the DONE cycle.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int inj_at, input bit chain,
                          input logic [31:0] chain_val);
        logic [31:0] hi_prev, lo_prev;
        int n, busy_cnt, done_at;
        bit iter;
        iter = (o <= 3'd1) || (DIV_EN && o <= 3'd3);
        hi_prev = hi_m;
        lo_prev = lo_m;
        @(negedge clk);
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); a_in = $urandom; b_in = $urandom;
        n = 1; busy_cnt = 0; done_at = -1;
        while (done_at < 0 && n < 40) begin
            if (done) begin
                done_at = n;
            end else begin
                if (busy) busy_cnt++;
                check({tag, "_hold_hi"}, hi, hi_prev);
                check({tag, "_hold_lo"}, lo, lo_prev);
                if (n == inj_at) begin
                    start = 1'b1; op = 3'd5; a_in = 32'd1;
                end
                @(posedge clk);
                @(negedge clk);
                start = 1'b0;
                n++;
            end
        end
        model(o, a, b);
        check({tag, "_latency"}, done_at, iter ? 33 : 1);
        check({tag, "_busy_cycles"}, busy_cnt, iter ? 32 : 0);
        check({tag, "_busy_in_done"}, busy, 1'b0);
        check({tag, "_hi"}, hi, hi_m);
        check({tag, "_lo"}, lo, lo_m);
        if (chain) begin
            start = 1'b1; op = 3'd4; a_in = chain_val;
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (chain) model(3'd4, chain_val, 32'd0);
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_busy_after"}, busy, 1'b0);
        check({tag, "_hi_after"}, hi, hi_m);
        check({tag, "_lo_after"}, lo, lo_m);
    endtask

    // Start an iterative op and reset it part-way through.
    task automatic abort_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input int at);
        int n, pulses;
        @(negedge clk);
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < at) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("abort_busy_before", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        hi_m = 32'd0;
        lo_m = 32'd0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_hi", hi, hi_m);
        check("abort_lo", lo, lo_m);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("abort_no_done", pulses, 0);
    endtask

    // Single-edge request with no done/busy expected (MTHI/MTLO/ignored ops).
    task automatic quick_op(input string tag, input logic [2:0] o, input logic [31:0] a);
        @(negedge clk);
        start = 1'b1; op = o; a_in = a; b_in = $urandom;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        model(o, a, 32'd0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_hi"}, hi, hi_m);
        check({tag, "_lo"}, lo, lo_m);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // Reset, with a simultaneous MTHI start that reset must override.
        rst = 1'b1; start = 1'b1; op = 3'd4; a_in = 32'hDEAD_BEEF; b_in = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        rst = 1'b0; start = 1'b0;

        // Directed cases.
        run_op("mult_neg3x5", 3'd0, 32'hFFFF_FFFD, 32'd5, -1, 1'b0, 32'd0);
        check("mult_neg3x5_hi_const", hi, 32'hFFFF_FFFF);
        check("mult_neg3x5_lo_const", lo, 32'hFFFF_FFF1);
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, 32'd0);
        check("multu_max_hi_const", hi, 32'hFFFF_FFFE);
        check("multu_max_lo_const", lo, 32'h0000_0001);
        run_op("div_neg7by2", 3'd2, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, 32'd0);
        run_op("divu_by0", 3'd3, 32'd100, 32'd0, -1, 1'b0, 32'd0);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, 32'd0);
        run_op("div_by0_signed", 3'd2, 32'hFFFF_FF00, 32'd0, -1, 1'b0, 32'd0);
        run_op("mult_6x7_inj", 3'd0, 32'd6, 32'd7, 10, 1'b0, 32'd0);
        check("mult_6x7_hi_const", hi, 32'd0);
        check("mult_6x7_lo_const", lo, 32'd42);

        // Abort, then a fresh MULTU.
        abort_op(DIV_EN ? 3'd2 : 3'd1, 32'd1000, 32'd7, 15);
        run_op("multu_2x3", 3'd1, 32'd2, 32'd3, -1, 1'b0, 32'd0);
        check("multu_2x3_lo_const", lo, 32'd6);

        // MTHI then MTLO back-to-back.
        quick_op("mthi", 3'd4, 32'h1234_5678);
        quick_op("mtlo", 3'd5, 32'd9);
        check("mt_pair_hi_const", hi, 32'h1234_5678);

        // Ignored op codes.
        quick_op("op6", 3'd6, $urandom);
        quick_op("op7", 3'd7, $urandom);

        // Request accepted in the DONE cycle.
        run_op("chain", 3'd1, 32'd11, 32'd13, -1, 1'b1, 32'hCAFE_0001);

        // Randomized operations.
        for (int i = 0; i < 16; i++) begin
            run_op("rand", 3'($urandom_range(0, 3)), pick(), pick(), -1, 1'b0, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
